// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : Two-entry fetch-to-decode skid queue with flush, HALT freeze
//                and dropped-push diagnostic.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int          DEPTH      = 2,
    parameter logic [15:0] NOP_INSTR  = 16'h0800,
    parameter logic [15:0] HALT_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instrF,
    input  logic [15:0] incPCF,
    input  logic        validF,
    output logic        readyF,
    input  logic        stallD,
    input  logic        flush,
    output logic [15:0] instrD,
    output logic [15:0] incPCD,
    output logic        validD,
    output logic        haltHeld,
    output logic        err
);

    localparam int c_ENTRIES = DEPTH;

    logic [15:0] r_instr [c_ENTRIES];
    logic [15:0] r_incPC [c_ENTRIES];
    logic        r_rdPtr;
    logic        r_wrPtr;
    logic [1:0]  r_count;
    logic        r_haltHeld;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    assign w_full   = (r_count == 2'd2);
    assign w_empty  = (r_count == 2'd0);

    // No bypass from full: a same-cycle pop never frees a slot for intake.
    assign readyF   = ~w_full & ~r_haltHeld & ~flush;
    assign w_push   = validF & readyF;
    assign validD   = ~w_empty;
    assign w_pop    = validD & ~stallD & ~flush;
    assign err      = validF & ~readyF & ~flush & ~r_haltHeld & w_full;
    assign haltHeld = r_haltHeld;

    assign instrD   = w_empty ? NOP_INSTR : r_instr[r_rdPtr];
    assign incPCD   = w_empty ? 16'h0000  : r_incPC[r_rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr    <= 1'b0;
            r_wrPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_haltHeld <= 1'b0;
        end else if (flush) begin
            r_rdPtr    <= 1'b0;
            r_wrPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_haltHeld <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && (instrF == HALT_INSTR)) begin
                r_haltHeld <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wrPtr] <= instrF;
            r_incPC[r_wrPtr] <= incPCF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Directed scoreboard bench for if_id_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] instrF;
    logic [15:0] incPCF;
    logic        validF;
    logic        readyF;
    logic        stallD;
    logic        flush;
    logic [15:0] instrD;
    logic [15:0] incPCD;
    logic        validD;
    logic        haltHeld;
    logic        err;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] sbq [$];

    if_id_buffer #(
        .DEPTH      (2),
        .NOP_INSTR  (16'h0800),
        .HALT_INSTR (16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instrF   (instrF),
        .incPCF   (incPCF),
        .validF   (validF),
        .readyF   (readyF),
        .stallD   (stallD),
        .flush    (flush),
        .instrD   (instrD),
        .incPCD   (incPCD),
        .validD   (validD),
        .haltHeld (haltHeld),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p, input logic acc);
        validF = v;
        instrF = i;
        incPCF = p;
        if (acc) sbq.push_back({i, p});
    endtask

    // Monitor: every consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && validD && !stallD && !flush) begin
            if (sbq.size() == 0) begin
                chk("popUnexpected", {instrD, incPCD}, 32'hxxxx_xxxx);
            end else begin
                chk("popData", {instrD, incPCD}, sbq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; stallD = 1'b0; flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        #2;
        chk("rstValidD", {31'd0, validD}, 32'd0);
        chk("rstInstrD", {16'd0, instrD}, 32'h0800);
        chk("rstIncPCD", {16'd0, incPCD}, 32'h0000);
        chk("rstReadyF", {31'd0, readyF}, 32'd1);
        chk("rstErr", {31'd0, err}, 32'd0);
        chk("rstHalt", {31'd0, haltHeld}, 32'd0);
        step(); step();
        rst = 1'b1;

        // Single push, one-cycle latency, then drain
        step(); drive(1'b1, 16'h4002, 16'h0002, 1'b1);
        @(negedge clk);
        chk("pushReady", {31'd0, readyF}, 32'd1);
        chk("noPassThru", {31'd0, validD}, 32'd0);
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("oneValid", {31'd0, validD}, 32'd1);
        chk("oneInstr", {16'd0, instrD}, 32'h4002);
        chk("onePC", {16'd0, incPCD}, 32'h0002);
        step();
        @(negedge clk);
        chk("oneEmpty", {31'd0, validD}, 32'd0);
        chk("oneNop", {16'd0, instrD}, 32'h0800);

        // Fill under stall, overflow err, hold stable, drain in order
        step(); stallD = 1'b1; drive(1'b1, 16'h1111, 16'h0004, 1'b1);
        @(negedge clk);
        chk("fillReady0", {31'd0, readyF}, 32'd1);
        step(); drive(1'b1, 16'h2222, 16'h0006, 1'b1);
        @(negedge clk);
        chk("fillReady1", {31'd0, readyF}, 32'd1);
        chk("fillHead", {16'd0, instrD}, 32'h1111);
        step(); drive(1'b1, 16'h3333, 16'h0008, 1'b0);
        @(negedge clk);
        chk("fullReady", {31'd0, readyF}, 32'd0);
        chk("fullErr", {31'd0, err}, 32'd1);
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("errPulse", {31'd0, err}, 32'd0);
        chk("fullReady2", {31'd0, readyF}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("holdStable", {validD, readyF, err, 13'd0, instrD}, {3'b100, 13'd0, 16'h1111});
        end
        step(); stallD = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("drainEmpty", {31'd0, validD}, 32'd0);

        // Simultaneous push/pop at count 1 across pointer wrap
        step(); drive(1'b1, 16'hA001, 16'h0020, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(); drive(1'b1, 16'hB000 + 16'(k), 16'h0022 + 16'(2 * k), 1'b1);
            @(negedge clk);
            chk("ppReady", {31'd0, readyF}, 32'd1);
            chk("ppValid", {31'd0, validD}, 32'd1);
        end
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        @(negedge clk);
        chk("ppEmpty", {31'd0, validD}, 32'd0);

        // Flush while full with a concurrent push
        step(); stallD = 1'b1; drive(1'b1, 16'h5555, 16'h0030, 1'b1);
        step(); drive(1'b1, 16'h6666, 16'h0032, 1'b1);
        step(); drive(1'b1, 16'h7777, 16'h0034, 1'b0); flush = 1'b1; sbq.delete();
        @(negedge clk);
        chk("flushErr", {31'd0, err}, 32'd0);
        chk("flushReady", {31'd0, readyF}, 32'd0);
        step(); flush = 1'b0; stallD = 1'b0; drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("postFlushValid", {31'd0, validD}, 32'd0);
        chk("postFlushReady", {31'd0, readyF}, 32'd1);
        chk("postFlushErr", {31'd0, err}, 32'd0);
        step();
        @(negedge clk);
        chk("flushNotStored", {31'd0, validD}, 32'd0);

        // HALT freezes intake until flush
        step(); drive(1'b1, 16'h0000, 16'h0010, 1'b1);
        @(negedge clk);
        chk("haltPushReady", {31'd0, readyF}, 32'd1);
        step(); drive(1'b1, 16'h9999, 16'h0012, 1'b0);
        @(negedge clk);
        chk("haltSet", {31'd0, haltHeld}, 32'd1);
        chk("haltReady", {31'd0, readyF}, 32'd0);
        chk("haltNoErr", {31'd0, err}, 32'd0);
        chk("haltHead", {15'd0, validD, instrD}, {15'd0, 1'b1, 16'h0000});
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("haltDrained", {31'd0, validD}, 32'd0);
        chk("haltKept", {31'd0, haltHeld}, 32'd1);
        step(); flush = 1'b1;
        step(); flush = 1'b0;
        @(negedge clk);
        chk("haltCleared", {31'd0, haltHeld}, 32'd0);
        chk("haltReadyBack", {31'd0, readyF}, 32'd1);

        // Asynchronous reset mid-cycle while full
        step(); stallD = 1'b1; drive(1'b1, 16'hAAAA, 16'h0040, 1'b1);
        step(); drive(1'b1, 16'hBBBB, 16'h0042, 1'b1);
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("asyncValid", {31'd0, validD}, 32'd0);
        chk("asyncInstr", {16'd0, instrD}, 32'h0800);
        chk("asyncPC", {16'd0, incPCD}, 32'h0000);
        chk("asyncReady", {31'd0, readyF}, 32'd1);
        sbq.delete();
        @(negedge clk); #1;
        rst = 1'b1; stallD = 1'b0;
        step(); drive(1'b1, 16'h1234, 16'h0050, 1'b1);
        @(negedge clk);
        chk("firstPushReady", {31'd0, readyF}, 32'd1);
        step(); drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("firstPushValid", {31'd0, validD}, 32'd1);
        step();
        @(negedge clk);
        chk("sbDrained", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
